// File: rtl/full_adder_checker.sv
// Self-test engine for a 1-bit full adder: sweeps {A,B,C} over 0..7, compares F against A+B+C,
// and reports pass/fail, a saturating mismatch count and the first failing vector.
module full_adder_checker #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned ERR_W         = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  output logic             A_o,
  output logic             B_o,
  output logic             C_o,
  input  logic [1:0]       F_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [ERR_W-1:0] err_cnt_o,
  output logic [2:0]       first_fail_vec_o,
  output logic [1:0]       first_fail_val_o
);

  localparam int unsigned SET_W = 4;
  localparam logic [SET_W-1:0] LP_SETTLE  = SET_W'(SETTLE_CYCLES);
  localparam logic [ERR_W-1:0] LP_ERR_MAX = '1;

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CHECK, ST_DONE} state_t;

  state_t           r_state;
  logic [2:0]       r_vec;
  logic [SET_W-1:0] r_settle;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [ERR_W-1:0] r_err;
  logic [2:0]       r_ff_vec;
  logic [1:0]       r_ff_val;

  logic [1:0] w_exp;
  logic       w_mismatch;
  logic       w_err_zero;

  assign w_exp      = 2'(r_vec[2]) + 2'(r_vec[1]) + 2'(r_vec[0]);
  assign w_mismatch = (F_i != w_exp);
  assign w_err_zero = (r_err == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_vec    <= 3'd0;
      r_settle <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
      r_err    <= '0;
      r_ff_vec <= 3'd0;
      r_ff_val <= 2'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        // The closing edge of DONE is also the IDLE re-entry edge, so a start seen there begins a run.
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            r_vec    <= 3'd0;
            r_settle <= LP_SETTLE;
            r_err    <= '0;
            r_pass   <= 1'b0;
            r_ff_vec <= 3'd0;
            r_ff_val <= 2'd0;
            r_busy   <= 1'b1;
            r_state  <= ST_SETTLE;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SETTLE: begin
          r_settle <= r_settle - SET_W'(1);
          if (r_settle == SET_W'(1)) r_state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (w_mismatch) begin
            if (r_err != LP_ERR_MAX) r_err <= r_err + ERR_W'(1);
            if (w_err_zero) begin
              r_ff_vec <= r_vec;
              r_ff_val <= F_i;
            end
          end
          if (r_vec != 3'd7) begin
            r_vec    <= r_vec + 3'd1;
            r_settle <= LP_SETTLE;
            r_state  <= ST_SETTLE;
          end else begin
            r_vec   <= 3'd0;
            r_pass  <= w_err_zero && !w_mismatch;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign {A_o, B_o, C_o}  = r_vec;
  assign busy_o           = r_busy;
  assign done_o           = r_done;
  assign pass_o           = r_pass;
  assign err_cnt_o        = r_err;
  assign first_fail_vec_o = r_ff_vec;
  assign first_fail_val_o = r_ff_val;

endmodule

// File: tb/tb_full_adder_checker.sv
// Scoreboard bench for full_adder_checker: three instances (S=1/ERR_W=4, S=4, ERR_W=2) with adder models.
module tb_full_adder_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic st1, st4, st2;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic a1, b1, c1, busy1, done1, pass1;
  logic a4, b4, c4, busy4, done4, pass4;
  logic a2, b2, c2, busy2, done2, pass2;
  logic [3:0] err1, err4;
  logic [1:0] err2;
  logic [2:0] ffvec1, ffvec4, ffvec2;
  logic [1:0] ffval1, ffval4, ffval2;
  logic [1:0] f1, f4, f2, g1, g4;

  int mode1 = 0;
  int dly4  = 3;
  logic [1:0] pipe4 [8];

  // Adder models: golden / carry stuck at 0, golden delayed by dly4 cycles, and output tied to 3.
  assign g1 = 2'(a1) + 2'(b1) + 2'(c1);
  assign f1 = (mode1 == 1) ? {1'b0, g1[0]} : g1;
  assign g4 = 2'(a4) + 2'(b4) + 2'(c4);
  always @(posedge clk) begin
    pipe4[0] <= g4;
    for (int i = 1; i < 8; i++) pipe4[i] <= pipe4[i-1];
  end
  assign f4 = pipe4[dly4-1];
  assign f2 = 2'b11;

  full_adder_checker #(.SETTLE_CYCLES(1), .ERR_W(4)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(st1), .A_o(a1), .B_o(b1), .C_o(c1), .F_i(f1),
    .busy_o(busy1), .done_o(done1), .pass_o(pass1), .err_cnt_o(err1),
    .first_fail_vec_o(ffvec1), .first_fail_val_o(ffval1));

  full_adder_checker #(.SETTLE_CYCLES(4), .ERR_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .start_i(st4), .A_o(a4), .B_o(b4), .C_o(c4), .F_i(f4),
    .busy_o(busy4), .done_o(done4), .pass_o(pass4), .err_cnt_o(err4),
    .first_fail_vec_o(ffvec4), .first_fail_val_o(ffval4));

  full_adder_checker #(.SETTLE_CYCLES(1), .ERR_W(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(st2), .A_o(a2), .B_o(b2), .C_o(c2), .F_i(f2),
    .busy_o(busy2), .done_o(done2), .pass_o(pass2), .err_cnt_o(err2),
    .first_fail_vec_o(ffvec2), .first_fail_val_o(ffval2));

  typedef struct {
    int done_cyc;
    int pass;
    int err;
    int vec;
    int val;
  } exp_t;

  exp_t q1[$], q4[$], q2[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic exp_t mk(input int dc, input int p, input int e, input int v, input int val);
    exp_t r;
    r.done_cyc = dc; r.pass = p; r.err = e; r.vec = v; r.val = val;
    return r;
  endfunction

  task automatic cmp(input string tag, input exp_t e, input int p, input int er, input int v, input int val);
    chk({tag, "_done_cycle"}, cyc, e.done_cyc);
    chk({tag, "_pass"}, p, e.pass);
    chk({tag, "_err_cnt"}, er, e.err);
    if (e.err != 0) begin
      chk({tag, "_first_vec"}, v, e.vec);
      chk({tag, "_first_val"}, val, e.val);
    end
  endtask

  // Monitors: pop the expected result whenever an instance pulses done_o.
  always @(negedge clk) begin : mon1
    exp_t e;
    if (done1 === 1'b1) begin
      if (q1.size() == 0) chk("dut1_unexpected_done", 1, 0);
      else begin
        e = q1.pop_front();
        cmp("dut1", e, int'(pass1), int'(err1), int'(ffvec1), int'(ffval1));
      end
    end
  end

  always @(negedge clk) begin : mon4
    exp_t e;
    if (done4 === 1'b1) begin
      if (q4.size() == 0) chk("dut4_unexpected_done", 1, 0);
      else begin
        e = q4.pop_front();
        cmp("dut4", e, int'(pass4), int'(err4), int'(ffvec4), int'(ffval4));
      end
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (done2 === 1'b1) begin
      if (q2.size() == 0) chk("dut2_unexpected_done", 1, 0);
      else begin
        e = q2.pop_front();
        cmp("dut2", e, int'(pass2), int'(err2), int'(ffvec2), int'(ffval2));
      end
    end
  end

  task automatic go(input int which);
    case (which)
      1: st1 = 1'b1;
      4: st4 = 1'b1;
      default: st2 = 1'b1;
    endcase
    @(negedge clk);
    st1 = 1'b0; st4 = 1'b0; st2 = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((q1.size() + q4.size() + q2.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_pending_results"}, q1.size() + q4.size() + q2.size(), 0);
    q1.delete(); q4.delete(); q2.delete();
  endtask

  initial begin
    int e0;
    rst = 1'b1; st1 = 1'b0; st4 = 1'b0; st2 = 1'b0;
    repeat (10) @(negedge clk);
    chk("reset_vec1", int'({a1, b1, c1}), 0);
    chk("reset_busy1", int'(busy1), 0);
    chk("reset_done1", int'(done1), 0);
    chk("reset_pass1", int'(pass1), 0);
    chk("reset_err1", int'(err1), 0);
    chk("reset_busy4", int'(busy4), 0);
    chk("reset_err2", int'(err2), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Golden adder, one-cycle start: busy/vector timeline, done after edge 16.
    mode1 = 0;
    e0 = cyc + 1;
    q1.push_back(mk(e0 + 16, 1, 0, 0, 0));
    st1 = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      if (k == 0) st1 = 1'b0;
      chk($sformatf("golden_busy_edge%0d", k), int'(busy1), (k <= 15) ? 1 : 0);
      if (k % 2 == 0) chk($sformatf("golden_vec_edge%0d", k), int'({a1, b1, c1}), (k < 16) ? k / 2 : 0);
    end
    drain("golden", 20);

    // Carry output stuck at 0.
    mode1 = 1;
    @(negedge clk);
    e0 = cyc + 1;
    q1.push_back(mk(e0 + 16, 0, 4, 3, 0));
    go(1);
    drain("stuck", 40);
    repeat (3) @(negedge clk);
    chk("stuck_hold_err", int'(err1), 4);
    chk("stuck_hold_pass", int'(pass1), 0);

    // Restart after a failing run clears results at the start edge.
    mode1 = 0;
    @(negedge clk);
    e0 = cyc + 1;
    q1.push_back(mk(e0 + 16, 1, 0, 0, 0));
    go(1);
    chk("restart_err_clear", int'(err1), 0);
    chk("restart_ffvec_clear", int'(ffvec1), 0);
    drain("restart", 40);

    // Start held high edges 0..20: one done, second run from edge 17.
    @(negedge clk);
    e0 = cyc + 1;
    q1.push_back(mk(e0 + 16, 1, 0, 0, 0));
    q1.push_back(mk(e0 + 33, 1, 0, 0, 0));
    st1 = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      if (k == 16) chk("held_busy_edge16", int'(busy1), 0);
      if (k == 17) chk("held_busy_edge17", int'(busy1), 1);
    end
    st1 = 1'b0;
    drain("held", 40);

    // Reset pulse while vector 4 is applied aborts without done_o.
    @(negedge clk);
    st1 = 1'b1;
    @(negedge clk);
    st1 = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort_vec_before_reset", int'({a1, b1, c1}), 4);
    #1 rst = 1'b1;
    #1;
    chk("abort_vec", int'({a1, b1, c1}), 0);
    chk("abort_busy", int'(busy1), 0);
    chk("abort_done", int'(done1), 0);
    chk("abort_err", int'(err1), 0);
    #1 rst = 1'b0;
    repeat (30) @(negedge clk);
    e0 = cyc + 1;
    q1.push_back(mk(e0 + 16, 1, 0, 0, 0));
    go(1);
    drain("after_abort", 40);

    // S=4 with 3-cycle model delay passes; with 5-cycle delay it fails on vectors 1,3,4,5,7.
    dly4 = 3;
    @(negedge clk);
    e0 = cyc + 1;
    q4.push_back(mk(e0 + 40, 1, 0, 0, 0));
    go(4);
    drain("s4_delay3", 80);
    repeat (10) @(negedge clk);
    dly4 = 5;
    e0 = cyc + 1;
    q4.push_back(mk(e0 + 40, 0, 5, 1, 0));
    go(4);
    drain("s4_delay5", 80);

    // ERR_W=2 with F tied to 3: counter saturates at 3.
    @(negedge clk);
    e0 = cyc + 1;
    q2.push_back(mk(e0 + 16, 0, 3, 0, 3));
    go(2);
    drain("errw2", 40);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
